// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: state encoding shared by the bit-serial subtractor controller.
package serial_sub_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/hs.sv
// hs: one-bit half subtractor, d = a - b with borrow out.
module hs (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bout
);
  assign d    = a ^ b;
  assign bout = ~a & b;
endmodule

// File: rtl/serial_sub_ctrl_fs_cell.sv
// fs_cell: combinational one-bit full subtractor built from two half subtractors.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1, b1, b2;
  hs u_hs0 (.a(a),  .b(b),   .d(d1), .bout(b1));
  hs u_hs1 (.a(d1), .b(bin), .d(d),  .bout(b2));
  assign bout = b1 | b2;
endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: LSB-first bit-serial WIDTH-bit subtractor sequencer around fs_cell.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow
);
  localparam int CW = $clog2(WIDTH);
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic bin_q, bin_d, borrow_q, borrow_d, cell_d, cell_bout, last;
  fs_cell u_cell (.a(a_q[0]), .b(b_q[0]), .bin(bin_q), .d(cell_d), .bout(cell_bout));
  assign last = cnt_q == CW'(WIDTH - 1);
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    if (state_q == SHIFT) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      res_d = {cell_d, res_q[WIDTH-1:1]};
      bin_d = cell_bout;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        state_d  = DONE;
        diff_d   = res_d;
        borrow_d = cell_bout;
      end
    end else if (start) begin
      state_d = SHIFT;
      a_d     = a;
      b_d     = b;
      bin_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end
`ifdef SERIAL_SUB_OVF_EN
  // Operand MSBs are lost to the shift, so keep copies for the overflow rule.
  logic a_msb_q, b_msb_q, ovf_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (state_q != SHIFT && start) begin
        a_msb_q <= a[WIDTH-1];
        b_msb_q <= b[WIDTH-1];
      end
      if (state_q == SHIFT && last) ovf_q <= (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
    end
  end
  assign ovf = ovf_q;
`endif
  assign busy   = state_q == SHIFT;
  assign done   = state_q == DONE;
  assign diff   = diff_q;
  assign borrow = borrow_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: directed self-checking bench for serial_sub_ctrl at WIDTH=8.
module tb_serial_sub_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, busy, done, borrow;
  logic [7:0] a = '0, b = '0, diff;
`ifdef SERIAL_SUB_OVF_EN
  logic ovf;
`endif
  int pass_cnt = 0, total = 0;

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff),
`ifdef SERIAL_SUB_OVF_EN
    .ovf(ovf),
`endif
    .borrow(borrow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, output int cyc,
                        output logic [7:0] dv, output logic bo, output logic ov);
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = -1; dv = 'x; bo = 1'bx; ov = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done) begin
        cyc = k; dv = diff; bo = borrow;
`ifdef SERIAL_SUB_OVF_EN
        ov = ovf;
`else
        ov = 1'b0;
`endif
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
    total++; if (diff !== 8'h00) $display("FAIL reset_diff got %h want 00", diff); else pass_cnt++;
    total++; if (borrow !== 1'b0) $display("FAIL reset_borrow got %b want 0", borrow); else pass_cnt++;
`ifdef SERIAL_SUB_OVF_EN
    total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else pass_cnt++;
`endif
  endtask

  task automatic test_subtract();
    logic [7:0] va [5] = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h7F};
    logic [7:0] vb [5] = '{8'h03, 8'h05, 8'h01, 8'h01, 8'hFF};
    logic [7:0] vd [5] = '{8'h02, 8'hFE, 8'hFF, 8'h7F, 8'h80};
    logic       vbo[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       vov[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int cyc;
    logic [7:0] dv;
    logic bo, ov;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], cyc, dv, bo, ov);
      total++; if (cyc != 8) $display("FAIL sub%0d_latency got %0d want 8", i, cyc); else pass_cnt++;
      total++; if (dv !== vd[i]) $display("FAIL sub%0d_diff got %h want %h", i, dv, vd[i]); else pass_cnt++;
      total++; if (bo !== vbo[i]) $display("FAIL sub%0d_borrow got %b want %b", i, bo, vbo[i]); else pass_cnt++;
`ifdef SERIAL_SUB_OVF_EN
      total++; if (ov !== vov[i]) $display("FAIL sub%0d_ovf got %b want %b", i, ov, vov[i]); else pass_cnt++;
`endif
      total++; if (busy !== 1'b0) $display("FAIL sub%0d_busy_at_done got %b want 0", i, busy); else pass_cnt++;
      tick();
      total++; if (done !== 1'b0) $display("FAIL sub%0d_done_pulse got %b want 0", i, done); else pass_cnt++;
      total++; if (diff !== vd[i]) $display("FAIL sub%0d_diff_hold got %h want %h", i, diff, vd[i]); else pass_cnt++;
    end
  endtask

  task automatic test_ignore_start();
    int dcount = 0, dedge = -1, overlap = 0;
    logic [7:0] dval = '0;
    a = 8'h20; b = 8'h05; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 3) begin a = 8'h01; b = 8'h02; start = 1'b1; end
      if (k == 4) start = 1'b0;
      tick();
      if (busy && done) overlap++;
      if (done) begin dcount++; dedge = k; dval = diff; end
    end
    total++; if (dcount != 1) $display("FAIL ignore_done_count got %0d want 1", dcount); else pass_cnt++;
    total++; if (dedge != 8) $display("FAIL ignore_done_edge got %0d want 8", dedge); else pass_cnt++;
    total++; if (dval !== 8'h1B) $display("FAIL ignore_diff got %h want 1b", dval); else pass_cnt++;
    total++; if (overlap != 0) $display("FAIL ignore_busy_done_overlap got %0d want 0", overlap); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int dcount = 0, cyc;
    logic [7:0] dv;
    logic bo, ov;
    a = 8'h00; b = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else pass_cnt++;
    total++; if (done !== 1'b0) $display("FAIL rstmid_done got %b want 0", done); else pass_cnt++;
    total++; if (diff !== 8'h00) $display("FAIL rstmid_diff got %h want 00", diff); else pass_cnt++;
    total++; if (borrow !== 1'b0) $display("FAIL rstmid_borrow got %b want 0", borrow); else pass_cnt++;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) dcount++;
    end
    total++; if (dcount != 0) $display("FAIL rstmid_no_done got %0d want 0", dcount); else pass_cnt++;
    run_op(8'h10, 8'h01, cyc, dv, bo, ov);
    total++; if (cyc != 8) $display("FAIL rstmid_fresh_latency got %0d want 8", cyc); else pass_cnt++;
    total++; if (dv !== 8'h0F) $display("FAIL rstmid_fresh_diff got %h want 0f", dv); else pass_cnt++;
    total++; if (bo !== 1'b0) $display("FAIL rstmid_fresh_borrow got %b want 0", bo); else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    int dcount = 0, e0 = -1, e1 = -1;
    logic [7:0] d0 = '0, d1 = '0, mid = '0;
    logic b0 = 1'b0, b1 = 1'b0;
    a = 8'h09; b = 8'h04; start = 1'b1;
    tick();
    for (int k = 1; k <= 22; k++) begin
      if (k == 2) begin a = 8'h04; b = 8'h09; end
      if (k == 10) start = 1'b0;
      tick();
      if (k == 13) mid = diff;
      if (done) begin
        if (dcount == 0) begin e0 = k; d0 = diff; b0 = borrow; end
        else if (dcount == 1) begin e1 = k; d1 = diff; b1 = borrow; end
        dcount++;
      end
    end
    total++; if (dcount != 2) $display("FAIL b2b_done_count got %0d want 2", dcount); else pass_cnt++;
    total++; if (e0 != 8) $display("FAIL b2b_first_edge got %0d want 8", e0); else pass_cnt++;
    total++; if (e1 != 17) $display("FAIL b2b_second_edge got %0d want 17", e1); else pass_cnt++;
    total++; if (d0 !== 8'h05 || b0 !== 1'b0) $display("FAIL b2b_first_result got %h/%b want 05/0", d0, b0); else pass_cnt++;
    total++; if (mid !== 8'h05) $display("FAIL b2b_diff_held got %h want 05", mid); else pass_cnt++;
    total++; if (d1 !== 8'hFB || b1 !== 1'b1) $display("FAIL b2b_second_result got %h/%b want fb/1", d1, b1); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_subtract();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
